// File: rtl/sync_mem_responder.sv
`default_nettype none
// ============================================================================
// Module : sync_mem_responder
// Brief  : Two-core atomic load/store responder over a shared byte memory,
//          one transaction at a time with round-robin core arbitration.
// Rev    : 1.0
// ============================================================================

module sync_mem_responder #(
    parameter int CORE_AMOUNT      = 2,
    parameter int DATA_MEMORY_SIZE = 256,
    parameter int ADDR_WIDTH_DM    = 8,
    parameter int DOUBLEWORD_WIDTH = 64,
    parameter int DATA_TYPE_WIDTH  = 2,
    parameter int FINISH_TIMEOUT   = 16
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic [CORE_AMOUNT-1:0]                   rd_ins,
    input  logic [CORE_AMOUNT*ADDR_WIDTH_DM-1:0]     addr_rd,
    input  logic [CORE_AMOUNT*DATA_TYPE_WIDTH-1:0]   data_type_rd,
    input  logic [CORE_AMOUNT-1:0]                   rd_finish,
    output logic [CORE_AMOUNT*DOUBLEWORD_WIDTH-1:0]  data_bus_rd,
    output logic [CORE_AMOUNT-1:0]                   rd_access,
    output logic [CORE_AMOUNT-1:0]                   rd_idle,
    input  logic [CORE_AMOUNT-1:0]                   wr_ins,
    input  logic [CORE_AMOUNT*ADDR_WIDTH_DM-1:0]     addr_wr,
    input  logic [CORE_AMOUNT*DATA_TYPE_WIDTH-1:0]   data_type_wr,
    input  logic [CORE_AMOUNT*DOUBLEWORD_WIDTH-1:0]  data_bus_wr,
    output logic [CORE_AMOUNT-1:0]                   wr_access,
    output logic [CORE_AMOUNT-1:0]                   wr_idle
);

    localparam int                 c_NUM_BYTES = DOUBLEWORD_WIDTH / 8;
    localparam int                 c_CNT_W     = $clog2(FINISH_TIMEOUT + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST  = c_CNT_W'(FINISH_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_RD_GRANT = 3'd1,
        S_RD_WAIT  = 3'd2,
        S_WR_GRANT = 3'd3,
        S_WR_DONE  = 3'd4
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic                 r_cur;
    logic [c_CNT_W-1:0]   r_cnt;

    logic [CORE_AMOUNT-1:0]      r_rd_pend;
    logic [CORE_AMOUNT-1:0]      r_wr_pend;
    logic [ADDR_WIDTH_DM-1:0]    r_rd_addr [CORE_AMOUNT];
    logic [ADDR_WIDTH_DM-1:0]    r_wr_addr [CORE_AMOUNT];
    logic [DATA_TYPE_WIDTH-1:0]  r_rd_type [CORE_AMOUNT];
    logic [DATA_TYPE_WIDTH-1:0]  r_wr_type [CORE_AMOUNT];
    logic [DOUBLEWORD_WIDTH-1:0] r_wr_data [CORE_AMOUNT];
    logic [DOUBLEWORD_WIDTH-1:0] r_rd_data [CORE_AMOUNT];
    logic [7:0]                  r_mem     [DATA_MEMORY_SIZE];

    logic [CORE_AMOUNT-1:0]      w_rd_req;
    logic [CORE_AMOUNT-1:0]      w_wr_req;
    logic [CORE_AMOUNT-1:0]      w_any_req;
    logic                        w_grant_core;
    logic                        w_grant_valid;
    logic                        w_grant_rd;
    logic                        w_grant_fire;

    logic [ADDR_WIDTH_DM-1:0]    w_rd_addr_cur;
    logic [ADDR_WIDTH_DM-1:0]    w_wr_addr_cur;
    logic [DOUBLEWORD_WIDTH-1:0] w_wr_data_cur;
    logic [3:0]                  w_rd_bytes;
    logic [3:0]                  w_wr_bytes;
    logic [DOUBLEWORD_WIDTH-1:0] w_rd_word;

    logic                        w_rd_busy;
    logic                        w_wr_busy;
    logic                        w_rd_done_now;
    logic                        w_wr_done_now;

    // A pulse arriving at the arbitration edge counts as already pending.
    assign w_rd_req  = r_rd_pend | rd_ins;
    assign w_wr_req  = r_wr_pend | wr_ins;
    assign w_any_req = w_rd_req | w_wr_req;

    // r_cur doubles as the last-served core for round-robin fairness.
    always_comb begin
        w_grant_core = 1'b0;
        if (w_any_req[0] && w_any_req[1]) begin
            w_grant_core = ~r_cur;
        end else if (w_any_req[1]) begin
            w_grant_core = 1'b1;
        end
    end

    assign w_grant_valid = |w_any_req;
    assign w_grant_rd    = w_rd_req[w_grant_core];
    assign w_grant_fire  = (r_state == S_IDLE) && w_grant_valid;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_grant_valid) begin
                    w_state_next = w_grant_rd ? S_RD_GRANT : S_WR_GRANT;
                end
            end
            S_RD_GRANT: w_state_next = S_RD_WAIT;
            S_RD_WAIT: begin
                if (rd_finish[r_cur] || (r_cnt == c_CNT_LAST)) begin
                    w_state_next = S_IDLE;
                end
            end
            S_WR_GRANT: w_state_next = S_WR_DONE;
            S_WR_DONE:  w_state_next = S_IDLE;
            default:    w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cur   <= 1'b1;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_grant_fire) begin
                r_cur <= w_grant_core;
            end
            if (r_state == S_RD_WAIT) begin
                r_cnt <= r_cnt + c_CNT_W'(1);
            end else begin
                r_cnt <= '0;
            end
        end
    end

    // Request capture: latest pulse wins; the granted direction is cleared.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_pend <= '0;
            r_wr_pend <= '0;
            for (int c = 0; c < CORE_AMOUNT; c++) begin
                r_rd_addr[c] <= '0;
                r_wr_addr[c] <= '0;
                r_rd_type[c] <= '0;
                r_wr_type[c] <= '0;
                r_wr_data[c] <= '0;
                r_rd_data[c] <= '0;
            end
        end else begin
            for (int c = 0; c < CORE_AMOUNT; c++) begin
                if (rd_ins[c]) begin
                    r_rd_pend[c] <= 1'b1;
                    r_rd_addr[c] <= addr_rd[c*ADDR_WIDTH_DM +: ADDR_WIDTH_DM];
                    r_rd_type[c] <= data_type_rd[c*DATA_TYPE_WIDTH +: DATA_TYPE_WIDTH];
                end
                if (wr_ins[c]) begin
                    r_wr_pend[c] <= 1'b1;
                    r_wr_addr[c] <= addr_wr[c*ADDR_WIDTH_DM +: ADDR_WIDTH_DM];
                    r_wr_type[c] <= data_type_wr[c*DATA_TYPE_WIDTH +: DATA_TYPE_WIDTH];
                    r_wr_data[c] <= data_bus_wr[c*DOUBLEWORD_WIDTH +: DOUBLEWORD_WIDTH];
                end
                if (w_grant_fire && (int'(w_grant_core) == c)) begin
                    if (w_grant_rd) begin
                        r_rd_pend[c] <= 1'b0;
                    end else begin
                        r_wr_pend[c] <= 1'b0;
                    end
                end
                if ((r_state == S_RD_GRANT) && (int'(r_cur) == c)) begin
                    r_rd_data[c] <= w_rd_word;
                end
            end
        end
    end

    assign w_rd_addr_cur = r_rd_addr[r_cur];
    assign w_wr_addr_cur = r_wr_addr[r_cur];
    assign w_wr_data_cur = r_wr_data[r_cur];
    assign w_rd_bytes    = 4'd1 << r_rd_type[r_cur];
    assign w_wr_bytes    = 4'd1 << r_wr_type[r_cur];

    // Little-endian gather with address wrap; bytes beyond the size read as zero.
    always_comb begin
        w_rd_word = '0;
        for (int i = 0; i < c_NUM_BYTES; i++) begin
            if (i < int'(w_rd_bytes)) begin
                w_rd_word[8*i +: 8] =
                    r_mem[ADDR_WIDTH_DM'(w_rd_addr_cur + ADDR_WIDTH_DM'(i))];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DATA_MEMORY_SIZE; i++) begin
                r_mem[i] <= '0;
            end
        end else if (r_state == S_WR_GRANT) begin
            for (int i = 0; i < c_NUM_BYTES; i++) begin
                if (i < int'(w_wr_bytes)) begin
                    r_mem[ADDR_WIDTH_DM'(w_wr_addr_cur + ADDR_WIDTH_DM'(i))] <=
                        w_wr_data_cur[8*i +: 8];
                end
            end
        end
    end

    assign w_rd_busy     = (r_state == S_RD_GRANT) || (r_state == S_RD_WAIT);
    assign w_wr_busy     = (r_state == S_WR_GRANT) || (r_state == S_WR_DONE);
    assign w_rd_done_now = (r_state == S_RD_WAIT) && (r_cnt == '0);
    assign w_wr_done_now = (r_state == S_WR_DONE);

    for (genvar c = 0; c < CORE_AMOUNT; c++) begin : g_core
        localparam logic c_ID = 1'(c);
        assign rd_access[c] = w_rd_busy && (r_cur == c_ID);
        assign rd_idle[c]   = w_rd_done_now && (r_cur == c_ID);
        assign wr_access[c] = w_wr_busy && (r_cur == c_ID);
        assign wr_idle[c]   = w_wr_done_now && (r_cur == c_ID);
        assign data_bus_rd[c*DOUBLEWORD_WIDTH +: DOUBLEWORD_WIDTH] = r_rd_data[c];
    end

endmodule

`default_nettype wire
